// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
//   Shared definitions for the ALU operand/opcode sequencer:
//   - default operand, opcode and result widths
//   - sequencer state encoding (IDLE, LOAD, EXEC, DONE)
//   - ALU opcode constants
//   - packed program entry {a, key} at the default widths
package alu_op_sequencer_pkg;

    localparam int SEQ_A_W   = 4;
    localparam int SEQ_KEY_W = 3;
    localparam int SEQ_RES_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [SEQ_KEY_W-1:0] OP_ADD_RIPPLE = 3'b000;
    localparam logic [SEQ_KEY_W-1:0] OP_ADD        = 3'b001;
    localparam logic [SEQ_KEY_W-1:0] OP_ORXOR      = 3'b010;
    localparam logic [SEQ_KEY_W-1:0] OP_ANY        = 3'b011;
    localparam logic [SEQ_KEY_W-1:0] OP_ALL        = 3'b100;
    localparam logic [SEQ_KEY_W-1:0] OP_SHL        = 3'b101;
    localparam logic [SEQ_KEY_W-1:0] OP_SHR        = 3'b110;
    localparam logic [SEQ_KEY_W-1:0] OP_MUL        = 3'b111;

    // Operand in the upper bits, opcode in the lower bits; the sequencer
    // stores entries in its buffer with this same layout.
    typedef struct packed {
        logic [SEQ_A_W-1:0]   a;
        logic [SEQ_KEY_W-1:0] key;
    } entry_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// seq_fifo
//   Circular FIFO holding DEPTH entries of W bits. Pointers wrap naturally
//   (DEPTH must be a power of two). The head entry is presented
//   combinationally on dout_o.
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     push_i, din_i      push request and data (dropped when full)
//     pop_i              pop request (ignored when empty)
//     dout_o             head entry
//     full_o, empty_o    occupancy flags
//     count_o            entries held (0..DEPTH)
//   Push and pop acceptance are both judged on the current count, so a push
//   into a full FIFO is dropped even when a pop happens in the same cycle.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO via the pointers/count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Buffers (A operand, opcode) pairs and, on start, issues them one by one
//   to an external combinational ALU. The ALU B operand is the low A_W bits
//   of the accumulator and every result is captured back into it, so a
//   buffered program runs as a chain of dependent operations.
//   Each op takes two cycles (LOAD, EXEC); the done pulse coincides with the
//   first cycle the final accumulator value is visible.
//   Handshake: wr_en is a one-cycle push request with no back-pressure other
//   than full; a request seen while full is dropped. start is a one-cycle
//   request honoured only in IDLE with a non-empty buffer.
//   Ports:
//     clock, reset        clock, synchronous active-high reset
//     wr_en/wr_a/wr_key   program entry push
//     start               begin executing the buffered program
//     alu_result          combinational ALU result
//     alu_a/alu_b/alu_key operands and opcode driven to the ALU
//     acc                 accumulator (display value)
//     full/empty/count    buffer occupancy
//     busy                high in LOAD and EXEC
//     done                one-cycle completion pulse
//     overflow            sticky dropped-push flag
//     state               current sequencer state (debug visibility)
//   Configuration macro: ALU_SEQ_OVERFLOW_EN builds the sticky overflow flag;
//   without it overflow is tied low. Push dropping is identical either way.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int A_W   = SEQ_A_W,
    parameter int KEY_W = SEQ_KEY_W,
    parameter int RES_W = SEQ_RES_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [A_W-1:0]         wr_a,
    input  logic [KEY_W-1:0]       wr_key,
    input  logic                   start,
    input  logic [RES_W-1:0]       alu_result,
    output logic [A_W-1:0]         alu_a,
    output logic [A_W-1:0]         alu_b,
    output logic [KEY_W-1:0]       alu_key,
    output logic [RES_W-1:0]       acc,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output seq_state_t             state
);

    localparam int EW = A_W + KEY_W;

    seq_state_t       state_q;
    logic [A_W-1:0]   alu_a_q;
    logic [KEY_W-1:0] alu_key_q;
    logic [RES_W-1:0] acc_q;
    logic             busy_q;
    logic             done_q;

    logic [EW-1:0]    head;
    logic             push_ok;
    logic             pop;

    assign push_ok = wr_en & ~full;
    assign pop     = (state_q == LOAD);

    seq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (wr_en),
        .din_i   ({wr_a, wr_key}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_key_q <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !empty) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    alu_a_q   <= head[EW-1:KEY_W];
                    alu_key_q <= head[KEY_W-1:0];
                    state_q   <= EXEC;
                end
                EXEC: begin
                    acc_q <= alu_result;
                    // A push landing in this very cycle still belongs to the
                    // running program.
                    if (!empty || push_ok) begin
                        state_q <= LOAD;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_key = alu_key_q;
    assign acc     = acc_q;
    // Only the low bits feed back; upper result bits stay display-only.
    assign alu_b   = acc_q[A_W-1:0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign state   = state_q;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Drives the sequencer with a behavioural ALU in the loop. Expected
//   accumulator values are computed when entries are pushed and compared
//   as each op's result becomes visible.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_a = '0;
    logic [2:0] wr_key = '0;
    logic       start = 1'b0;
    logic [7:0] alu_result;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_key;
    logic [7:0] acc;
    logic       full, empty, busy, done, overflow;
    logic [2:0] count;
    seq_state_t state;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_acc = '0;
    int         mcount = 0;
    logic       exp_ovf = 1'b0;

    always #5 clock = ~clock;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] k);
        logic [7:0] ae, be;
        ae = {4'b0, a};
        be = {4'b0, b};
        case (k)
            OP_ADD_RIPPLE, OP_ADD: return ae + be;
            OP_ORXOR: return {a | b, a ^ b};
            OP_ANY:   return {7'b0, |{a, b}};
            OP_ALL:   return {7'b0, &{a, b}};
            OP_SHL:   return be << a;
            OP_SHR:   return be >> a;
            default:  return ae * be;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_key);

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_a       (wr_a),
        .wr_key     (wr_key),
        .start      (start),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_key    (alu_key),
        .acc        (acc),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .state      (state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        exp_q.delete();
        model_acc = '0;
        mcount = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_push(input logic [3:0] a, input logic [2:0] k);
        logic [7:0] e;
        if (mcount < DEPTH) begin
            e = alu_f(a, model_acc[3:0], k);
            model_acc = e;
            exp_q.push_back(e);
            mcount++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic do_push(input logic [3:0] a, input logic [2:0] k);
        wr_en = 1'b1;
        wr_a = a;
        wr_key = k;
        model_push(a, k);
        cycle();
        wr_en = 1'b0;
        vectors++;
        if (count !== 3'(mcount)) begin
            miscompares++;
            $display("FAIL push_count: got %0d want %0d", count, mcount);
        end
    endtask

    // Starts the program and follows it cycle by cycle: LOAD on odd cycles,
    // EXEC on even cycles, DONE on cycle 2n+1. Optionally pushes one more
    // entry during the first LOAD cycle.
    task automatic run_program(input int n, input bit late_push,
                               input logic [3:0] la, input logic [2:0] lk);
        seq_state_t prev, want_st;
        logic [7:0] e;
        start = 1'b1;
        prev = state;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 2 * n + 1; c++) begin
            if (late_push && c == 1) begin
                wr_en = 1'b1;
                wr_a = la;
                wr_key = lk;
                model_push(la, lk);
            end
            if (c == 2 * n + 1)  want_st = DONE;
            else if (c % 2 == 1) want_st = LOAD;
            else                 want_st = EXEC;
            vectors++;
            if (state !== want_st) begin
                miscompares++;
                $display("FAIL run_state c=%0d: got %0d want %0d", c, state, want_st);
            end
            vectors++;
            if (busy !== (c <= 2 * n)) begin
                miscompares++;
                $display("FAIL run_busy c=%0d: got %0b want %0b", c, busy, (c <= 2 * n));
            end
            vectors++;
            if (done !== (c == 2 * n + 1)) begin
                miscompares++;
                $display("FAIL run_done c=%0d: got %0b want %0b", c, done, (c == 2 * n + 1));
            end
            vectors++;
            if (alu_b !== acc[3:0]) begin
                miscompares++;
                $display("FAIL run_alu_b c=%0d: got %h want %h", c, alu_b, acc[3:0]);
            end
            if (prev == EXEC) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL run_acc c=%0d: got %h want <none queued>", c, acc);
                end else begin
                    e = exp_q.pop_front();
                    if (acc !== e) begin
                        miscompares++;
                        $display("FAIL run_acc c=%0d: got %h want %h", c, acc, e);
                    end
                end
            end
            prev = state;
            cycle();
            if (late_push && c == 1) wr_en = 1'b0;
        end
        mcount -= n;
        vectors++;
        if (state !== IDLE || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL run_end: state %0d done %0b busy %0b want IDLE/0/0", state, done, busy);
        end
        vectors++;
        if (count !== 3'(mcount) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL run_drain: count %0d queued %0d want %0d/0", count, exp_q.size(), mcount);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        cycle();
        vectors++;
        if (acc !== 8'h00 || alu_a !== 4'h0 || alu_key !== 3'h0 || alu_b !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_datapath: acc %h a %h key %h b %h want all 0", acc, alu_a, alu_key, alu_b);
        end
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fifo: count %0d empty %0b full %0b want 0/1/0", count, empty, full);
        end
        vectors++;
        if (state !== IDLE || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: state %0d busy %0b done %0b ovf %0b want IDLE/0/0/0",
                     state, busy, done, overflow);
        end
    endtask

    task automatic test_program();
        apply_reset();
        do_push(4'd3, OP_ADD_RIPPLE);
        do_push(4'd5, OP_MUL);
        do_push(4'd1, OP_SHL);
        run_program(3, 1'b0, 4'd0, 3'd0);
        vectors++;
        if (acc !== 8'h1E) begin
            miscompares++;
            $display("FAIL program_final_acc: got %h want 1e", acc);
        end
    endtask

    task automatic test_full();
        logic want_ovf;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            do_push(4'(i), OP_ADD);
            vectors++;
            if (full !== (i >= 4)) begin
                miscompares++;
                $display("FAIL full_flag push %0d: got %0b want %0b", i, full, (i >= 4));
            end
        end
`ifdef ALU_SEQ_OVERFLOW_EN
        want_ovf = exp_ovf;
`else
        want_ovf = 1'b0;
`endif
        vectors++;
        if (overflow !== want_ovf) begin
            miscompares++;
            $display("FAIL full_overflow: got %0b want %0b", overflow, want_ovf);
        end
        run_program(4, 1'b0, 4'd0, 3'd0);
        vectors++;
        if (acc !== 8'h0A) begin
            miscompares++;
            $display("FAIL full_final_acc: got %h want 0a", acc);
        end
    endtask

    task automatic test_empty_start();
        logic [7:0] acc_before;
        acc_before = acc;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (state !== IDLE || done !== 1'b0 || busy !== 1'b0 || acc !== acc_before) begin
                miscompares++;
                $display("FAIL empty_start: state %0d done %0b busy %0b acc %h want IDLE/0/0/%h",
                         state, done, busy, acc, acc_before);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_push_during_exec();
        apply_reset();
        do_push(4'd2, OP_ADD);
        run_program(2, 1'b1, 4'd4, OP_ADD);
        vectors++;
        if (acc !== 8'h06) begin
            miscompares++;
            $display("FAIL late_push_final_acc: got %h want 06", acc);
        end
    endtask

    task automatic test_reset_mid_op();
        do_push(4'd7, OP_ADD);
        do_push(4'd9, OP_ADD);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        vectors++;
        if (state !== EXEC) begin
            miscompares++;
            $display("FAIL midrst_reach_exec: got %0d want %0d", state, EXEC);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        model_acc = '0;
        mcount = 0;
        exp_ovf = 1'b0;
        vectors++;
        if (acc !== 8'h00 || count !== 3'd0 || state !== IDLE || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: acc %h count %0d state %0d done %0b want 0/0/IDLE/0",
                     acc, count, state, done);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            vectors++;
            if (done !== 1'b0 || state !== IDLE) begin
                miscompares++;
                $display("FAIL midrst_quiet: done %0b state %0d want 0/IDLE", done, state);
            end
        end
    endtask

    task automatic test_wrap();
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3; j++) begin
                do_push(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            end
            run_program(3, 1'b0, 4'd0, 3'd0);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_full();
        test_empty_start();
        test_push_during_exec();
        test_reset_mid_op();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
